// File: rtl/gpio_spi_pkg.sv
// Shared frame geometry and FSM encoding for the GPIO SPI slave front end.
package gpio_spi_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RW_BIT  = 15;
  localparam int unsigned CNT_W   = 5;

  localparam logic [CNT_W-1:0] CNT_HDR_LAST = 5'd7;
  localparam logic [CNT_W-1:0] CNT_FULL     = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT      = 5'd17;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_HDR,
    S_RD_LAT,
    S_WR,
    S_RD
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for an asynchronous pin with single-cycle rise/fall pulses.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/gpio_spi_slave.sv
// Oversampled SPI mode-0 slave: 16-bit frames to a strobe/address/data register bus,
// with byte readback shifted out on SDO.
module gpio_spi_slave
  import gpio_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SCLK,
  input  logic              SEN_N,
  input  logic              SDI,
  output logic              SDO,
  output logic              SDO_OE,
  output logic              STB,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DATA,
  input  logic [DATA_W-1:0] RD_DATA
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sen_lvl, sen_rise, sen_fall;
  logic unused_sclk_lvl;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk_i (CLK), .rst_ni(RST_N), .d_i(SCLK),
    .q_o   (sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sen_sync (
    .clk_i (CLK), .rst_ni(RST_N), .d_i(SEN_N),
    .q_o   (sen_lvl), .rise_o(sen_rise), .fall_o(sen_fall)
  );

  assign unused_sclk_lvl = sclk_lvl;

  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sdi_s;
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bad_q, bad_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  rd_byte_q, rd_byte_d;
  logic               sdo_q, sdo_d;
  logic               stb_q, stb_d;
  logic               stb_pend_q, stb_pend_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_WAIT_IDLE;
      cnt_q      <= '0;
      bad_q      <= 1'b0;
      sr_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_byte_q  <= '0;
      sdo_q      <= 1'b0;
      stb_q      <= 1'b0;
      stb_pend_q <= 1'b0;
      sdi_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      sr_q       <= sr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_byte_q  <= rd_byte_d;
      sdo_q      <= sdo_d;
      stb_q      <= stb_d;
      stb_pend_q <= stb_pend_d;
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], SDI};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bad_d      = bad_q;
    sr_d       = sr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_byte_d  = rd_byte_q;
    sdo_d      = sdo_q;
    stb_pend_d = 1'b0;
    // Commit is split over two cycles so STB, DATA and ADDR appear together
    // one CLK after the SEN_N rise is acted on; the shift register is frozen in IDLE.
    stb_d      = stb_pend_q;
    if (stb_pend_q) data_d = sr_q[DATA_W-1:0];

    unique case (state_q)
      S_WAIT_IDLE: begin
        cnt_d = '0;
        bad_d = 1'b0;
        if (sen_lvl) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = '0;
        bad_d = 1'b0;
        if (sen_fall) state_d = S_HDR;
      end
      default: begin
        if (sclk_rise) begin
          sr_d = {sr_q[FRAME_W-2:0], sdi_s};
          if (cnt_q >= CNT_FULL) begin
            cnt_d = CNT_SAT;
            bad_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
          if (state_q == S_HDR && cnt_q == CNT_HDR_LAST) begin
            addr_d  = {sr_q[ADDR_W-2:0], sdi_s};
            state_d = sr_q[ADDR_W-1] ? S_RD_LAT : S_WR;
          end
        end
        if (state_q == S_RD_LAT) begin
          rd_byte_d = RD_DATA;
          state_d   = S_RD;
        end
        if (state_q == S_RD && sclk_fall) begin
          sdo_d     = rd_byte_q[DATA_W-1];
          rd_byte_d = {rd_byte_q[DATA_W-2:0], 1'b0};
        end
        if (sen_rise) begin
          state_d = S_IDLE;
          sdo_d   = 1'b0;
          if (state_q == S_WR && cnt_q == CNT_FULL && !bad_q) stb_pend_d = 1'b1;
        end
      end
    endcase
  end

  assign SDO    = sdo_q;
  assign SDO_OE = (state_q == S_RD);
  assign STB    = stb_q;
  assign ADDR   = addr_q;
  assign DATA   = data_q;

endmodule

// File: tb/tb_gpio_spi_slave.sv
// Directed bench for gpio_spi_slave: frame-level model of expected strobes, held data and readback.
module tb_gpio_spi_slave;

  localparam int SYNC = 2;

  logic       CLK = 1'b0;
  logic       RST_N, SCLK, SEN_N, SDI;
  logic       SDO, SDO_OE, STB;
  logic [6:0] ADDR;
  logic [7:0] DATA, RD_DATA;

  logic [7:0] mem [128];
  assign RD_DATA = mem[ADDR];

  always #5 CLK = ~CLK;

  gpio_spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .SEN_N(SEN_N), .SDI(SDI),
    .SDO(SDO), .SDO_OE(SDO_OE), .STB(STB), .ADDR(ADDR), .DATA(DATA),
    .RD_DATA(RD_DATA)
  );

  typedef struct {
    int         c;
    logic [6:0] a;
    logic [7:0] d;
  } stb_ev_t;

  stb_ev_t    exp_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         stb_seen = 0;
  logic       chk_en = 1'b0;
  logic       oe_valid = 1'b1;
  logic       oe_exp = 1'b0;
  logic [7:0] m_data = '0;
  logic [7:0] rd_got;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Per-cycle compare against the frame-level model.
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      if (chk_en) begin
        logic exp_stb;
        exp_stb = (exp_q.size() > 0) && (exp_q[0].c == cyc);
        chk("stb", STB, exp_stb);
        if (STB) stb_seen++;
        if (exp_stb) begin
          m_data = exp_q[0].d;
          chk("stb_addr", ADDR, exp_q[0].a);
          void'(exp_q.pop_front());
        end
        chk("data_hold", DATA, m_data);
        if (oe_valid) begin
          chk("sdo_oe", SDO_OE, oe_exp);
          if (!oe_exp) chk("sdo_idle", SDO, 1'b0);
        end
      end
    end
  end

  // Drives one frame at CLK/8; a 16-bit write queues a strobe SYNC+2 CLK after the SEN_N rise.
  task automatic send_frame(input logic [15:0] f, input int nbits, input int gap,
                            output logic [7:0] got);
    logic [7:0] exp_byte;
    logic       is_rd;
    is_rd    = f[15] && (nbits == 16);
    exp_byte = mem[f[14:8]];
    got      = '0;
    SEN_N    = 1'b0;
    cycles(4);
    for (int i = 0; i < nbits; i++) begin
      SDI = (i < 16) ? f[15-i] : 1'b0;
      cycles(4);
      if (is_rd && i >= 8) begin
        if (i == 8) begin
          oe_valid = 1'b1;
          oe_exp   = 1'b1;
          chk("rd_addr", ADDR, f[14:8]);
        end
        chk("sdo_bit", SDO, exp_byte[15-i]);
        got[15-i] = SDO;
      end
      if (is_rd && i == 7) oe_valid = 1'b0;
      SCLK = 1'b1;
      cycles(4);
      SCLK = 1'b0;
    end
    cycles(4);
    SEN_N = 1'b1;
    SDI   = 1'b0;
    if (is_rd) oe_valid = 1'b0;
    if (nbits == 16 && !f[15]) exp_q.push_back('{c: cyc + SYNC + 2, a: f[14:8], d: f[7:0]});
    cycles(gap);
    if (is_rd) begin
      oe_valid = 1'b1;
      oe_exp   = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] part;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37) ^ 8'h5A;
    mem[7'h0A] = 8'hC3;
    mem[7'h15] = 8'h6E;
    RST_N = 1'b0; SEN_N = 1'b1; SCLK = 1'b0; SDI = 1'b0;
    cycles(4);
    RST_N = 1'b1;
    cycles(1);
    #1;
    chk("rst_sdo", SDO, 1'b0);
    chk("rst_sdo_oe", SDO_OE, 1'b0);
    chk("rst_stb", STB, 1'b0);
    chk("rst_addr", ADDR, 7'h00);
    chk("rst_data", DATA, 8'h00);
    chk_en = 1'b1;

    send_frame(16'h0A5C, 16, 6, rd_got);
    chk("wr1_addr", ADDR, 7'h0A);
    chk("wr1_data", DATA, 8'h5C);
    chk("wr1_stb_count", stb_seen, 1);

    send_frame(16'h8A00, 16, 6, rd_got);
    chk("rd1_byte", rd_got, 8'hC3);
    send_frame(16'h9500, 16, 6, rd_got);
    chk("rd2_byte", rd_got, 8'h6E);
    chk("rd_no_stb", stb_seen, 1);

    send_frame(16'h0A77, 15, 6, rd_got);
    send_frame(16'h0A77, 17, 6, rd_got);
    chk("bad_data_kept", DATA, 8'h5C);
    chk("bad_no_stb", stb_seen, 1);
    send_frame(16'h0111, 16, 6, rd_got);
    chk("after_bad_addr", ADDR, 7'h01);
    chk("after_bad_data", DATA, 8'h11);

    send_frame(16'h3F81, 16, SYNC + 2, rd_got);
    send_frame(16'h7F00, 16, 6, rd_got);
    chk("b2b_addr", ADDR, 7'h7F);
    chk("b2b_data", DATA, 8'h00);
    chk("b2b_stb_count", stb_seen, 4);

    // Reset after 10 bits of a write with SEN_N held low.
    part  = 16'h2A5C;
    SEN_N = 1'b0;
    cycles(4);
    for (int i = 0; i < 10; i++) begin
      SDI = part[15-i];
      cycles(4);
      SCLK = 1'b1;
      cycles(4);
      SCLK = 1'b0;
    end
    cycles(2);
    chk_en = 1'b0;
    RST_N  = 1'b0;
    cycles(2);
    RST_N = 1'b1;
    exp_q.delete();
    m_data = '0;
    cycles(1);
    #1;
    chk("midrst_sdo", SDO, 1'b0);
    chk("midrst_sdo_oe", SDO_OE, 1'b0);
    chk("midrst_stb", STB, 1'b0);
    chk("midrst_addr", ADDR, 7'h00);
    chk("midrst_data", DATA, 8'h00);
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      SDI = part[5-i];
      cycles(4);
      SCLK = 1'b1;
      cycles(4);
      SCLK = 1'b0;
    end
    cycles(4);
    SEN_N = 1'b1;
    cycles(8);
    chk("midrst_no_stb", stb_seen, 4);
    send_frame(16'h2299, 16, 6, rd_got);
    chk("post_rst_addr", ADDR, 7'h22);
    chk("post_rst_data", DATA, 8'h99);

    // SCLK activity with SEN_N high must be ignored.
    for (int i = 0; i < 6; i++) begin
      SDI = i[0];
      SCLK = 1'b1;
      cycles(4);
      SCLK = 1'b0;
      cycles(4);
    end
    SDI = 1'b0;
    cycles(4);
    chk("idle_sclk_no_stb", stb_seen, 5);
    send_frame(16'h5533, 16, 8, rd_got);
    chk("idle_sclk_addr", ADDR, 7'h55);
    chk("idle_sclk_data", DATA, 8'h33);
    chk("total_stb", stb_seen, 6);
    chk("stb_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_chk, n_err);
    $fatal(1);
  end

endmodule

// File: doc/gpio_spi_slave.md
# gpio_spi_slave

Serial-bus front end for the OZY GPIO control registers. It deserializes 16-bit SPI frames from the FX2 and drives the parallel strobe/address/data bus that every addressed 8-bit register instance decodes. It also serves readback frames by shifting out the byte the register file presents for the addressed location. Everything is oversampled in the single system clock domain; SCLK is never used as a clock.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for SCLK, SEN_N and SDI (minimum 2).

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  synchronous, active-low reset.
- SCLK  in  1  SPI clock from FX2, asynchronous; rate must be ≤ CLK/8.
- SEN_N  in  1  SPI frame enable, active low, asynchronous.
- SDI  in  1  SPI data in, MSB first, asynchronous.
- SDO  out  1  SPI data out; 0 when not shifting readback.
- SDO_OE  out  1  high while readback bits are being driven.
- STB  out  1  one-CLK write strobe to the register bus.
- ADDR  out  7  register address; held stable until the next frame's header completes.
- DATA  out  8  write data; held stable until the next valid write.
- RD_DATA  in  8  readback byte from the register mux, combinational from ADDR.

## Operation
- Frame: 16 bits, MSB first. Bit15 = RW (1 = read, 0 = write), bits14:8 = address, bits7:0 = data (write) or don't-care (read).
- SPI mode 0: SDI sampled on SCLK rising edges; SDO updated on SCLK falling edges.
- SCLK, SEN_N and SDI each pass through SYNC_STAGES flops; edges are detected from the last stage and the previous value.
- State machine:
  - WAIT_IDLE: entered on reset; go to IDLE once the synchronized SEN_N is high.
  - IDLE: bit counter = 0. SEN_N falling -> HDR.
  - HDR: shift on each rising SCLK. After the 8th bit, load ADDR from bits 6:0. If RW=0 -> WR. If RW=1, latch RD_DATA on the next CLK -> RD.
  - WR: shift 8 data bits into a staging register. SEN_N rising with count = 16: DATA <= staging and STB = 1 for one CLK, then -> IDLE.
  - RD: SDO_OE = 1. On each falling SCLK, SDO presents the next latched bit (bit7 first, on the first falling edge after the 8th rising edge). SDI is still counted. SEN_N rising -> IDLE, with SDO = 0 and SDO_OE = 0.
- Invalid frame: if SEN_N rises with count ≠ 16, or a 17th rising SCLK arrives, the frame is flagged bad. A bad frame issues no STB, DATA is unchanged and the FSM returns to IDLE at SEN_N rise. ADDR may already hold the bad frame's address.
- SCLK edges while SEN_N is high are ignored.
- Bit counter is 5 bits and saturates at 17; it never wraps.

## Timing
- Reset values: SDO = 0, SDO_OE = 0, STB = 0, ADDR = 0, DATA = 0, state = WAIT_IDLE, counter = 0, bad flag = 0.
- Input-to-detect latency: SYNC_STAGES + 1 CLK from any pin transition to the internal edge pulse. That is 3 CLK at default.
- STB asserts exactly SYNC_STAGES + 2 CLK after SEN_N rises at the pin, for one CLK. ADDR and DATA are valid on the same cycle and remain stable afterwards.
- RD_DATA is sampled one CLK after the 8th rising-edge detect. The external mux therefore has 1 CLK after ADDR updates.
- SDO changes SYNC_STAGES + 1 CLK after the SCLK falling edge at the pin. This is why SCLK must not exceed CLK/8: the margin to the FX2 sample point is half an SCLK period.
- Back-to-back frames: a new SEN_N fall is accepted on the CLK after the STB cycle. SEN_N high must last ≥ SYNC_STAGES + 2 CLK.
- RST_N low mid-frame: the frame is abandoned with no STB, and SDO_OE drops on the next CLK. The next frame is accepted only after SEN_N is seen high (WAIT_IDLE).

## Structure
- Shared package (gpio_spi_pkg): frame width 16, ADDR width 7, DATA width 8, RW bit index 15, and the FSM state encoding.
- One sub-module is natural: sync_edge (an N-stage synchronizer with rise/fall pulse outputs), instantiated for SCLK and SEN_N. SDI uses the synchronizer only.

## Test plan
- Write frame 0x0A5C (addr 0x0A, data 0x5C) at CLK/8 -> exactly one STB; ADDR = 0x0A, DATA = 0x5C; STB lands 4 CLK after SEN_N rise.
- Read frame with header 0x8A and RD_DATA = 0xC3 when ADDR = 0x0A -> SDO shows 1,1,0,0,0,0,1,1 on successive falling edges; SDO_OE is high only during the data phase; no STB.
- 15-bit frame, then 17-bit frame -> no STB for either; DATA keeps its prior value; the following valid write 0x0111 is accepted.
- Two write frames separated by the minimum SEN_N high time -> two STBs, with ADDR/DATA matching each frame.
- RST_N asserted after 10 bits of a write, with SEN_N still low -> no STB and outputs at reset values. Further SCLKs before SEN_N goes high are ignored; the next full frame after SEN_N high is accepted.
- SCLK toggling while SEN_N is high -> no state change and no STB.
